// File: rtl/rr_rank_if.sv
// Insert/remove bundle for the round-robin rank stage.
// master drives requests; slave (rr_rank) returns status and head entry.
interface rr_rank_if #(
  parameter int FLOW_ID_WIDTH = 16,
  parameter int RANK_WIDTH    = 16,
  parameter int META_WIDTH    = 16
);
  logic                     busy;
  logic                     insert;
  logic [META_WIDTH-1:0]    meta_in;
  logic [FLOW_ID_WIDTH-1:0] flowID_in;
  logic                     remove;
  logic                     valid_out;
  logic [RANK_WIDTH-1:0]    rank_out;
  logic [META_WIDTH-1:0]    meta_out;
  logic                     drop;

  modport master (
    output insert, meta_in, flowID_in, remove,
    input  busy, valid_out, rank_out, meta_out, drop
  );

  modport slave (
    input  insert, meta_in, flowID_in, remove,
    output busy, valid_out, rank_out, meta_out, drop
  );
endinterface

// File: rtl/rr_rank.sv
// Round-robin rank stage: per-flow rank = max(last+1, cur_round)
// with wrap-safe compare, two-stage pipe, show-ahead output ring.
module rr_rank #(
  parameter int FLOW_ID_WIDTH = 16,
  parameter int RANK_WIDTH    = 16,
  parameter int META_WIDTH    = 16,
  parameter int L2_NUM_FLOWS  = 4,
  parameter int L2_MAX_DEPTH  = 4
) (
  input  logic     clk,
  input  logic     rst,
  rr_rank_if.slave bus
);
  localparam int NUM_FLOWS = 1 << L2_NUM_FLOWS;
  localparam int DEPTH     = 1 << L2_MAX_DEPTH;
  localparam int CW        = L2_MAX_DEPTH + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] BUSY_AT = CW'(DEPTH - 2);

  typedef logic [RANK_WIDTH-1:0]   rank_t;
  typedef logic [META_WIDTH-1:0]   meta_t;
  typedef logic [L2_NUM_FLOWS-1:0] idx_t;
  typedef logic [L2_MAX_DEPTH-1:0] ptr_t;

  rank_t last_rank [NUM_FLOWS];
  rank_t cur_round;

  logic  s1_valid;
  idx_t  s1_idx;
  meta_t s1_meta;
  rank_t s1_last;

  rank_t mem_rank [DEPTH];
  meta_t mem_meta [DEPTH];
  ptr_t  head;
  ptr_t  tail;
  logic [CW-1:0] count;
  logic  drop_q;

  logic  accept;
  logic  pop;
  logic  push;
  logic  fwd;
  logic  later;
  idx_t  in_idx;
  rank_t cand;
  rank_t diff;
  rank_t s2_rank;

  logic unused_flow_bits;
  assign unused_flow_bits =
    ^bus.flowID_in[FLOW_ID_WIDTH-1:L2_NUM_FLOWS];

  assign bus.valid_out = (count != '0);
  assign bus.busy      = (count >= BUSY_AT);
  assign bus.drop      = drop_q;
  assign bus.rank_out  = bus.valid_out ? mem_rank[head] : '0;
  assign bus.meta_out  = bus.valid_out ? mem_meta[head] : '0;

  always_comb begin
    in_idx  = bus.flowID_in[L2_NUM_FLOWS-1:0];
    accept  = bus.insert && !bus.busy;
    pop     = bus.remove && bus.valid_out;
    push    = s1_valid;
    cand    = s1_last + rank_t'(1);
    // serial-number compare keeps ordering across wrap
    diff    = cand - cur_round;
    later   = (diff != '0) && !diff[RANK_WIDTH-1];
    s2_rank = later ? cand : cur_round;
    fwd     = s1_valid && (s1_idx == in_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_meta   <= '0;
      s1_last   <= '0;
      cur_round <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      drop_q    <= 1'b0;
      for (int i = 0; i < NUM_FLOWS; i++)
        last_rank[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_idx  <= in_idx;
        s1_meta <= bus.meta_in;
        s1_last <= fwd ? s2_rank : last_rank[in_idx];
      end
      if (push) begin
        last_rank[s1_idx] <= s2_rank;
        tail <= tail + ptr_t'(1);
      end
      if (pop) begin
        head      <= head + ptr_t'(1);
        cur_round <= bus.rank_out;
      end
      count  <= count + CW'(push) - CW'(pop);
      drop_q <= bus.insert && bus.busy;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rank[tail] <= s2_rank;
      mem_meta[tail] <= s1_meta;
    end
  end

  no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && count == FULL)
  );
endmodule
